// File: rtl/data_sram_responder.sv
// Data-SRAM responder: word memory with byte strobes, fixed response latency and
// a small in-order queue of accepted requests awaiting their data_ok pulse.
module data_sram_responder #(
    parameter int ADDR_BITS       = 12,
    parameter int LATENCY         = 1,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    input  logic        force_stall,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        misaligned_error
);

    localparam int AGE_W = $clog2(LATENCY + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [AGE_W-1:0] LAT_AGE  = AGE_W'(LATENCY);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

    typedef struct packed {
        logic                 is_write;
        logic [31:0]          rdata;
        logic [AGE_W-1:0]     age;
    } entry_t;

    logic [31:0]          r_mem [2**ADDR_BITS];
    entry_t               r_queue [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    logic                 r_misaligned;

    logic [ADDR_BITS-1:0] w_index;
    logic                 w_accept;
    logic                 w_retire;
    logic                 w_misaligned;
    entry_t               w_new_entry;
    logic                 w_unused_addr_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign w_index            = data_addr[ADDR_BITS+1:2];
    assign w_unused_addr_bits = ^{data_addr[31:ADDR_BITS+2], data_addr[1:0]};

    // addr_ok depends only on registered occupancy and force_stall, never on data_req.
    assign data_addr_ok = !reset && !force_stall && (r_count < MAX_CNT);
    assign w_accept     = data_req && data_addr_ok;

    // In-order with fixed latency: only the head can be due in any given cycle.
    assign w_retire         = (r_count != '0) && (r_queue[r_head].age == LAT_AGE);
    assign data_data_ok     = !reset && w_retire;
    assign data_rdata       = (data_data_ok && !r_queue[r_head].is_write) ? r_queue[r_head].rdata : 32'h0;
    assign misaligned_error = r_misaligned;

    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        w_misaligned = 1'b0;
        unique case (data_size)
            2'd0:    w_misaligned = 1'b0;
            2'd1:    w_misaligned = data_addr[0];
            2'd2:    w_misaligned = |data_addr[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        w_new_entry          = '0;
        w_new_entry.is_write = data_wr;
        w_new_entry.rdata    = data_wr ? 32'h0 : r_mem[w_index];
        w_new_entry.age      = AGE_W'(1);
    end

    // NOTE: memory and queue payload are deliberately not reset; occupancy alone says what is valid.
    always_ff @(posedge clock) begin
        if (w_accept && data_wr && !w_misaligned) begin
            for (int b = 0; b < 4; b++) begin
                if (data_wstrb[b]) begin
                    r_mem[w_index][8*b +: 8] <= data_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            r_queue[i].age <= r_queue[i].age + 1'b1;
        end
        if (w_accept) begin
            r_queue[r_tail] <= w_new_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_misaligned <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tail <= ptr_inc(r_tail);
            end
            if (w_retire) begin
                r_head <= ptr_inc(r_head);
            end
            unique case ({w_accept, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_accept && w_misaligned) begin
                r_misaligned <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: stimulus pushes expected responses,
// an independent monitor pops them whenever data_ok is seen.
module tb_data_sram_responder;

    localparam int AB   = 6;
    localparam int LAT  = 3;
    localparam int MAXO = 2;
    localparam int WORDS = 2**AB;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'd2;
    logic [31:0] data_addr = 32'h0;
    logic [3:0]  data_wstrb = 4'h0;
    logic [31:0] data_wdata = 32'h0;
    logic        force_stall = 1'b0;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        misaligned_error;

    data_sram_responder #(
        .ADDR_BITS      (AB),
        .LATENCY        (LAT),
        .MAX_OUTSTANDING(MAXO)
    ) u_dut (
        .clock           (clock),
        .reset           (reset),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_size       (data_size),
        .data_addr       (data_addr),
        .data_wstrb      (data_wstrb),
        .data_wdata      (data_wdata),
        .force_stall     (force_stall),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata),
        .misaligned_error(misaligned_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          acc_cycles[$];
    logic [31:0] mdl_mem [WORDS];
    bit          exp_err = 1'b0;
    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    // Requests accepted before cycle t whose response cycle has not yet passed.
    function automatic int outstanding(input int t);
        int n = 0;
        foreach (acc_cycles[i]) begin
            if (acc_cycles[i] < t && acc_cycles[i] + LAT >= t) n++;
        end
        return n;
    endfunction

    function automatic bit is_misaligned(input logic [1:0] size, input logic [31:0] addr);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return addr[0];
            2'd2:    return addr[1:0] != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    task automatic step(input bit req, input bit wr, input logic [1:0] size, input logic [31:0] addr,
                        input logic [3:0] strb, input logic [31:0] wdata, input bit stall,
                        output bit accepted);
        bit   exp_ok;
        int   idx;
        exp_t e;
        @(posedge clock);
        #1;
        reset       = 1'b0;
        data_req    = req;
        data_wr     = wr;
        data_size   = size;
        data_addr   = addr;
        data_wstrb  = strb;
        data_wdata  = wdata;
        force_stall = stall;
        @(negedge clock);
        exp_ok = !stall && (outstanding(cyc) < MAXO);
        check("addr_ok", {31'h0, data_addr_ok}, {31'h0, exp_ok});
        check("misaligned_error", {31'h0, misaligned_error}, {31'h0, exp_err});
        accepted = req && exp_ok;
        if (accepted) begin
            idx   = int'(addr[AB+1:2]);
            e.due = cyc + LAT;
            if (wr) begin
                e.rdata = 32'h0;
                if (!is_misaligned(size, addr)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (strb[b]) mdl_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                    end
                end
            end else begin
                e.rdata = mdl_mem[idx];
            end
            exp_q.push_back(e);
            acc_cycles.push_back(cyc);
            while (acc_cycles.size() > 0 && acc_cycles[0] + LAT < cyc) void'(acc_cycles.pop_front());
            if (is_misaligned(size, addr)) exp_err = 1'b1;
        end
    endtask

    task automatic issue(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [3:0] strb, input logic [31:0] wdata);
        bit acc = 1'b0;
        for (int t = 0; t < 16 && !acc; t++) begin
            step(1'b1, wr, size, addr, strb, wdata, 1'b0, acc);
        end
        if (!acc) begin
            n_vec++;
            n_fail++;
            $display("FAIL accept_timeout at cycle %0d: got no acceptance, want one within 16 cycles", cyc);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'd2, 32'h0, 4'h0, 32'h0, 1'b0, acc);
    endtask

    task automatic apply_reset(input int n);
        @(posedge clock);
        #1;
        reset       = 1'b1;
        data_req    = 1'b0;
        force_stall = 1'b0;
        exp_q.delete();
        acc_cycles.delete();
        exp_err = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check("addr_ok_in_reset", {31'h0, data_addr_ok}, 32'h0);
            if (i < n - 1) begin
                @(posedge clock);
                #1;
            end
        end
    endtask

    function automatic logic [31:0] rand_addr(input logic [1:0] size, input bit aligned);
        logic [31:0] a = $urandom;
        if (aligned && size == 2'd1) a[0] = 1'b0;
        if (aligned && size >= 2'd2) a[1:0] = 2'b00;
        return a;
    endfunction

    // Monitor: every data_ok pulse must match the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                check("data_ok_in_reset", {31'h0, data_data_ok}, 32'h0);
            end else if (data_data_ok) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_data_ok", {31'h0, data_data_ok}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("data_ok_cycle", 32'(cyc), 32'(e.due));
                    check("rdata", data_rdata, e.rdata);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check("missing_data_ok", {31'h0, data_data_ok}, 32'h1);
            end
        end
    end

    initial begin
        bit          acc;
        logic [4:0]  pat;
        logic [1:0]  sz;
        logic [31:0] keep;

        apply_reset(2);

        for (int i = 0; i < WORDS; i++) begin
            issue(1'b1, 2'd2, {$urandom_range(255, 0), 16'h0, 8'(i << 2)} & ~32'h3 | 32'(i << 2), 4'hF, $urandom);
        end
        idle(LAT + 2);

        issue(1'b1, 2'd2, 32'h10, 4'hF, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 32'h10, 4'h0, 32'h0);
        issue(1'b1, 2'd2, 32'h20, 4'hF, 32'h11223344);
        issue(1'b1, 2'd2, 32'h20, 4'b0010, 32'h0000AA00);
        issue(1'b1, 2'd2, 32'h20, 4'b1100, 32'h55660000);
        issue(1'b0, 2'd2, 32'h20, 4'h0, 32'h0);
        idle(LAT + 2);

        // Held request against an empty queue: occupancy limit gives 1,1,0,0,1.
        pat = '0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 2'd2, 32'(i << 2), 4'h0, 32'h0, 1'b0, acc);
            pat = {pat[3:0], data_addr_ok};
        end
        check("backpressure_pattern", {27'h0, pat}, 32'h19);
        idle(LAT + 2);

        issue(1'b0, 2'd2, 32'h0, 4'h0, 32'h0);
        issue(1'b0, 2'd2, 32'h4, 4'h0, 32'h0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'd2, 32'h8, 4'h0, 32'h0, 1'b1, acc);
        idle(LAT + 2);

        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom_range(2, 0));
            step($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, sz, rand_addr(sz, 1'b1),
                 4'($urandom), $urandom, $urandom_range(7, 0) == 0, acc);
        end
        idle(LAT + 2);

        issue(1'b0, 2'd2, 32'h22, 4'h0, 32'h0);
        issue(1'b1, 2'd1, 32'h21, 4'hF, 32'hFFFFFFFF);
        issue(1'b0, 2'd2, 32'h20, 4'h0, 32'h0);
        idle(LAT + 2);
        check("misaligned_sticky", {31'h0, misaligned_error}, 32'h1);

        for (int i = 0; i < 200; i++) begin
            sz = 2'($urandom_range(3, 0));
            step($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, sz, rand_addr(sz, 1'b0),
                 4'($urandom), $urandom, $urandom_range(7, 0) == 0, acc);
        end
        idle(LAT + 2);

        keep = $urandom;
        issue(1'b1, 2'd2, 32'h40, 4'hF, keep);
        idle(LAT + 2);
        issue(1'b0, 2'd2, 32'h44, 4'h0, 32'h0);
        issue(1'b0, 2'd2, 32'h48, 4'h0, 32'h0);
        apply_reset(2);
        step(1'b1, 1'b0, 2'd2, 32'h40, 4'h0, 32'h0, 1'b0, acc);
        check("addr_ok_after_reset", {31'h0, data_addr_ok}, 32'h1);
        check("err_cleared_by_reset", {31'h0, misaligned_error}, 32'h0);
        idle(LAT + 3);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
